imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Program loader: the write-side master for the instruction memory's write port (address, instr_in, write_enable).
- Consumes a byte stream, e.g. from a UART receiver or a testbench, through a valid/ready handshake.
- Assembles little-endian 32-bit instruction words and writes them to consecutive word addresses starting at 0.
- Holds the CPU stalled while a load is in progress.

Parameters:
- ADDR_WIDTH, 10, instruction-memory word-address width; depth = 2^ADDR_WIDTH words.
- PC_WIDTH, 12, width of the byte address driven to memory; must be at least ADDR_WIDTH+2.
- SYNC_BYTE, 8'hA5, byte value that starts a load frame.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_data  in  8  stream byte
- in_valid  in  1  in_data is valid
- in_ready  out  1  loader can accept a byte this cycle
- mem_addr  out  PC_WIDTH  byte address for the memory write; bits [1:0] always 0
- mem_wdata  out  32  instruction word to write
- mem_we  out  1  one-cycle write strobe
- cpu_hold  out  1  keep CPU in reset/stall while high
- load_done  out  1  one-cycle pulse when a frame completes successfully
- load_err  out  1  sticky error flag; cleared only by reset or the next SYNC_BYTE

Behaviour:
- Clocking and reset: one clock, all state updated on posedge clk. Reset is synchronous and active-high.
- Reset values: state=IDLE, mem_addr=0, mem_wdata=0, mem_we=0, cpu_hold=0, load_done=0, load_err=0, in_ready=1.
- Reset mid-frame aborts the frame immediately; any partial word is discarded and never written.
- Handshake: a byte is accepted in a cycle where in_valid && in_ready. in_ready is 1 in IDLE, LEN0, LEN1 and DATA; it is 0 in WRITE, DONE and ERR.
- IDLE:
  - Accepted bytes other than SYNC_BYTE are dropped.
  - SYNC_BYTE -> LEN0; clears load_err, sets cpu_hold=1 and resets the word counter.
- LEN0: accepted byte becomes count[7:0] -> LEN1.
- LEN1: accepted byte becomes count[15:8]. Then:
  - count == 0 -> DONE.
  - count > 2^ADDR_WIDTH -> ERR.
  - otherwise -> DATA, with mem_addr=0 and byte index=0.
- DATA:
  - Accepted bytes fill mem_wdata little-endian: byte index 0 goes to [7:0], index 3 goes to [31:24].
  - On acceptance of byte index 3 -> WRITE.
- WRITE:
  - Lasts exactly one cycle with mem_we=1, carrying the current mem_addr and mem_wdata.
  - Next cycle: mem_addr += 4 and words_written += 1.
  - If words_written now equals count -> DONE (or CHK when LOADER_CHECKSUM_EN is defined); else -> DATA.
  - Write latency: mem_we is asserted the cycle after the 4th byte of a word is accepted.
- DONE: one cycle; load_done=1 and cpu_hold=0 from the next cycle -> IDLE.
- ERR: one cycle; load_err=1 (sticky), cpu_hold=0 -> IDLE. No memory writes occur for an erroring frame.
- mem_we is never asserted outside WRITE.
- mem_addr wraps modulo 2^PC_WIDTH, but the count check guarantees no wrap within a legal frame.
- SYNC_BYTE seen inside LEN0, LEN1 or DATA is treated as ordinary data, not as a restart.
- in_valid held high continuously: throughput is one word per 5 cycles (4 accept cycles + 1 WRITE cycle).

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, state CHK accepts one more byte.
  - That byte is compared with the running XOR of all data bytes of the frame (length bytes excluded).
  - Match -> DONE; mismatch -> ERR, but the words already written remain in memory.
- Not defined: no CHK state; the frame ends after the last data word; the checksum logic is absent.

Test Plan:
- Reset, then stream A5,01,00,13,00,00,00 -> exactly one mem_we pulse with mem_addr=0x000, mem_wdata=0x00000013; load_done pulses on the following cycle; cpu_hold high from the LEN0 cycle until DONE.
- Frame A5,02,00 followed by 8 bytes 11..18 -> writes 0x14131211 at addr 0x000 and 0x18171615 at addr 0x004; in_ready=0 during each WRITE cycle.
- Bytes 00,FF,A5,00,00 -> leading bytes ignored; DONE reached with no mem_we; load_done pulses once.
- Length 0x0401 (1025 words > 1024) -> load_err=1, no mem_we, cpu_hold returns to 0; a following valid frame clears load_err.
- Reset asserted after 2 data bytes of a word, then a fresh 1-word frame -> no write from the aborted frame; new word written at addr 0x000.
- With LOADER_CHECKSUM_EN: frame of 1 word 01,02,03,04 + checksum 04 -> load_done; same frame with checksum 05 -> load_err=1, word still written at 0x000.

Source files
------------

// File: rtl/imem_loader.sv
// Program loader: turns a framed byte stream (SYNC, len_lo, len_hi, data...) into
// consecutive 32-bit instruction-memory writes. Define LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module imem_loader #(
    parameter int          ADDR_WIDTH = 10,
    parameter int          PC_WIDTH   = 12,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [PC_WIDTH-1:0] mem_addr,
    output logic [31:0]         mem_wdata,
    output logic                mem_we,
    output logic                cpu_hold,
    output logic                load_done,
    output logic                load_err
);

    // state | meaning
    // IDLE  | waiting for SYNC_BYTE, other bytes dropped
    // LEN0  | expecting word count low byte
    // LEN1  | expecting word count high byte, range check
    // DATA  | collecting the 4 bytes of a word, little-endian
    // WRITE | one-cycle memory write strobe
    // DONE  | one-cycle completion pulse
    // ERR   | one-cycle error, sets sticky load_err
    // CHK   | expecting checksum byte (checksum build only)
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
`ifdef LOADER_CHECKSUM_EN
        , CHK = 3'd7
`endif
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic [15:0] count;
    logic [15:0] words_written;
    logic [1:0]  byte_idx;
    logic [15:0] len_full;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign accept   = in_valid && in_ready;
    assign len_full = {in_data, count[7:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && in_data == SYNC_BYTE) state_next = LEN0;
            end
            LEN0: begin
                if (accept) state_next = LEN1;
            end
            LEN1: begin
                if (accept) begin
                    if (len_full == 16'd0)                   state_next = DONE;
                    else if ({1'b0, len_full} > MAX_WORDS)   state_next = ERR;
                    else                                     state_next = DATA;
                end
            end
            DATA: begin
                if (accept && byte_idx == 2'd3) state_next = WRITE;
            end
            WRITE: begin
                if (words_written + 16'd1 == count) begin
`ifdef LOADER_CHECKSUM_EN
                    state_next = CHK;
`else
                    state_next = DONE;
`endif
                end else begin
                    state_next = DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) state_next = (in_data == csum) ? DONE : ERR;
            end
`endif
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        load_done = 1'b0;
        case (state)
            IDLE, LEN0, LEN1, DATA: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            CHK:                    in_ready = 1'b1;
`endif
            WRITE:                  mem_we    = 1'b1;
            DONE:                   load_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count         <= '0;
            words_written <= '0;
            byte_idx      <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            cpu_hold      <= 1'b0;
            load_err      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum          <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept && in_data == SYNC_BYTE) begin
                        load_err      <= 1'b0;
                        cpu_hold      <= 1'b1;
                        words_written <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum          <= '0;
`endif
                    end
                end
                LEN0: begin
                    if (accept) count[7:0] <= in_data;
                end
                LEN1: begin
                    if (accept) begin
                        count[15:8] <= in_data;
                        mem_addr    <= '0;
                        byte_idx    <= '0;
                    end
                end
                DATA: begin
                    if (accept) begin
                        mem_wdata[{byte_idx, 3'b000} +: 8] <= in_data;
                        byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= csum ^ in_data;
`endif
                    end
                end
                WRITE: begin
                    mem_addr      <= mem_addr + PC_WIDTH'(4);
                    words_written <= words_written + 16'd1;
                end
                DONE, ERR: cpu_hold <= 1'b0;
                default: ;
            endcase
            // Set on entry so the flag is already visible during the ERR cycle.
            if (state_next == ERR) load_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized framed streams
// compared against a frame-parsing reference model.
module tb_imem_loader;
    localparam int ADDR_WIDTH = 10;
    localparam int PC_WIDTH   = 12;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [7:0]          in_data = 8'h00;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [PC_WIDTH-1:0] mem_addr;
    logic [31:0]         mem_wdata;
    logic                mem_we;
    logic                cpu_hold;
    logic                load_done;
    logic                load_err;

    imem_loader #(.ADDR_WIDTH(ADDR_WIDTH), .PC_WIDTH(PC_WIDTH), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .cpu_hold(cpu_hold),
        .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [PC_WIDTH-1:0] addr;
        logic [31:0]         data;
    } wr_t;
    typedef wr_t wq_t[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int gap_max = 0;
    int last_acc_cyc = 0;

    wr_t  wr_log[$];
    int   we_cyc[$];
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   ready_bad = 0;
    int   hold_bad = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_log.push_back({mem_addr, mem_wdata});
            we_cyc.push_back(cyc);
            if (in_ready) ready_bad++;
            if (!cpu_hold) hold_bad++;
        end
        if (prev_done && cpu_hold) hold_bad++;
        if (load_done) begin
            done_cnt++;
            done_cyc = cyc;
            if (!cpu_hold) hold_bad++;
        end
        prev_done = load_done;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference: parse the whole stream frame by frame.
    function automatic void model(input bq_t s, output wq_t w, output int done, output int err);
        int i;
        int len;
        logic [7:0] x;
        wr_t e;
        w = {};
        done = 0;
        err = 0;
        i = 0;
        while (i < s.size()) begin
            if (s[i] != 8'hA5) begin
                i++;
            end else begin
                err = 0;
                len = int'(s[i+1]) + 256 * int'(s[i+2]);
                i += 3;
                if (len == 0) begin
                    done++;
                end else if (len > (1 << ADDR_WIDTH)) begin
                    err = 1;
                end else begin
                    x = 8'h00;
                    for (int k = 0; k < len; k++) begin
                        e.addr = PC_WIDTH'(4 * k);
                        e.data = {s[i+3], s[i+2], s[i+1], s[i]};
                        x = x ^ s[i] ^ s[i+1] ^ s[i+2] ^ s[i+3];
                        w.push_back(e);
                        i += 4;
                    end
`ifdef LOADER_CHECKSUM_EN
                    if (s[i] == x) done++;
                    else err = 1;
                    i++;
`else
                    done++;
`endif
                end
            end
        end
    endfunction

    function automatic logic [7:0] xor_words(input bq_t d);
        logic [7:0] x = 8'h00;
        foreach (d[k]) x = x ^ d[k];
        return x;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        int g;
        g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        in_valid = 1'b0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        in_data = b;
        in_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout byte=%h in_ready=%b required=1", b, in_ready);
        end
        last_acc_cyc = cyc;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_stream(input bq_t s);
        foreach (s[i]) send_byte(s[i]);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1)    begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (mem_we !== 1'b0)      begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (cpu_hold !== 1'b0)    begin failures++; $display("FAIL reset_cpu_hold got=%b exp=0", cpu_hold); end
        checks++; if (load_done !== 1'b0)   begin failures++; $display("FAIL reset_load_done got=%b exp=0", load_done); end
        checks++; if (load_err !== 1'b0)    begin failures++; $display("FAIL reset_load_err got=%b exp=0", load_err); end
        checks++; if (mem_addr !== '0)      begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0)  begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    endtask

    task automatic test_single_word();
        int w0 = wr_log.size();
        int d0 = done_cnt;
        int acc;
        gap_max = 0;
        send_byte(8'hA5);
        checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL single_hold_len0 got=%b exp=1", cpu_hold); end
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        acc = last_acc_cyc;
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h13);
`endif
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (wr_log.size() - w0 != 1) begin
            failures++; $display("FAIL single_write_count got=%0d exp=1", wr_log.size() - w0);
        end else begin
            checks++; if (wr_log[w0].addr !== '0) begin failures++; $display("FAIL single_addr got=%h exp=000", wr_log[w0].addr); end
            checks++; if (wr_log[w0].data !== 32'h00000013) begin failures++; $display("FAIL single_data got=%h exp=00000013", wr_log[w0].data); end
            checks++; if (we_cyc[w0] != acc + 1) begin failures++; $display("FAIL single_we_latency got=%0d exp=%0d", we_cyc[w0], acc + 1); end
`ifndef LOADER_CHECKSUM_EN
            checks++; if (done_cyc != acc + 2) begin failures++; $display("FAIL single_done_cycle got=%0d exp=%0d", done_cyc, acc + 2); end
`endif
        end
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL single_done_count got=%0d exp=1", done_cnt - d0); end
        checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL single_hold_after got=%b exp=0", cpu_hold); end
    endtask

    task automatic test_two_words();
        int w0 = wr_log.size();
        int r0 = ready_bad;
        bq_t s = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
`ifdef LOADER_CHECKSUM_EN
        s.push_back(8'h11 ^ 8'h12 ^ 8'h13 ^ 8'h14 ^ 8'h15 ^ 8'h16 ^ 8'h17 ^ 8'h18);
`endif
        gap_max = 1;
        send_stream(s);
        checks++;
        if (wr_log.size() - w0 != 2) begin
            failures++; $display("FAIL two_write_count got=%0d exp=2", wr_log.size() - w0);
        end else begin
            checks++; if (wr_log[w0] !== {12'h000, 32'h14131211}) begin failures++; $display("FAIL two_word0 got=%h/%h exp=000/14131211", wr_log[w0].addr, wr_log[w0].data); end
            checks++; if (wr_log[w0+1] !== {12'h004, 32'h18171615}) begin failures++; $display("FAIL two_word1 got=%h/%h exp=004/18171615", wr_log[w0+1].addr, wr_log[w0+1].data); end
        end
        checks++; if (ready_bad != r0) begin failures++; $display("FAIL two_ready_in_write got=%0d exp=0", ready_bad - r0); end
    endtask

    task automatic test_leading_junk();
        int w0 = wr_log.size();
        int d0 = done_cnt;
        gap_max = 0;
        send_stream('{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00});
        checks++; if (wr_log.size() != w0) begin failures++; $display("FAIL junk_writes got=%0d exp=0", wr_log.size() - w0); end
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL junk_done got=%0d exp=1", done_cnt - d0); end
        checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL junk_err got=%b exp=0", load_err); end
    endtask

    task automatic test_len_err();
        int w0 = wr_log.size();
        int d0 = done_cnt;
        logic [7:0] b[4];
        bq_t s;
        gap_max = 0;
        send_stream('{8'hA5, 8'h01, 8'h04});
        checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL lenerr_err got=%b exp=1", load_err); end
        checks++; if (wr_log.size() != w0) begin failures++; $display("FAIL lenerr_writes got=%0d exp=0", wr_log.size() - w0); end
        checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL lenerr_hold got=%b exp=0", cpu_hold); end
        checks++; if (done_cnt != d0) begin failures++; $display("FAIL lenerr_done got=%0d exp=0", done_cnt - d0); end
        send_byte(8'hA5);
        checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL lenerr_clear got=%b exp=0", load_err); end
        foreach (b[k]) b[k] = 8'($urandom);
        s = '{8'h01, 8'h00, b[0], b[1], b[2], b[3]};
`ifdef LOADER_CHECKSUM_EN
        s.push_back(b[0] ^ b[1] ^ b[2] ^ b[3]);
`endif
        send_stream(s);
        checks++;
        if (wr_log.size() - w0 != 1) begin
            failures++; $display("FAIL lenerr_next_count got=%0d exp=1", wr_log.size() - w0);
        end else if (wr_log[w0] !== {12'h000, b[3], b[2], b[1], b[0]}) begin
            failures++; $display("FAIL lenerr_next_word got=%h/%h exp=000/%h%h%h%h", wr_log[w0].addr, wr_log[w0].data, b[3], b[2], b[1], b[0]);
        end
        checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL lenerr_after got=%b exp=0", load_err); end
    endtask

    task automatic test_reset_abort();
        int w0 = wr_log.size();
        bq_t s = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
`ifdef LOADER_CHECKSUM_EN
        s.push_back(8'h04);
`endif
        gap_max = 0;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
        do_reset();
        checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL abort_hold got=%b exp=0", cpu_hold); end
        send_stream(s);
        checks++;
        if (wr_log.size() - w0 != 1) begin
            failures++; $display("FAIL abort_count got=%0d exp=1", wr_log.size() - w0);
        end else if (wr_log[w0] !== {12'h000, 32'h04030201}) begin
            failures++; $display("FAIL abort_word got=%h/%h exp=000/04030201", wr_log[w0].addr, wr_log[w0].data);
        end
    endtask

    task automatic test_random();
        bq_t s;
        bq_t d;
        wq_t ew;
        int ed;
        int ee;
        int w0 = wr_log.size();
        int d0 = done_cnt;
        int len;
        int kind;
        logic [7:0] b;
        gap_max = 2;
        for (int f = 0; f < 20; f++) begin
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                s.push_back(b);
            end
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                s.push_back(8'hA5); s.push_back(8'h00); s.push_back(8'h00);
            end else if (kind == 1) begin
                len = int'($urandom_range(1025, 65535));
                s.push_back(8'hA5); s.push_back(8'(len)); s.push_back(8'(len >> 8));
            end else begin
                len = int'($urandom_range(1, 5));
                s.push_back(8'hA5); s.push_back(8'(len)); s.push_back(8'h00);
                d = {};
                for (int k = 0; k < 4 * len; k++) d.push_back((($urandom % 8) == 0) ? 8'hA5 : 8'($urandom));
                foreach (d[k]) s.push_back(d[k]);
`ifdef LOADER_CHECKSUM_EN
                s.push_back(xor_words(d) ^ ((kind == 2) ? 8'h01 : 8'h00));
`endif
            end
        end
        model(s, ew, ed, ee);
        send_stream(s);
        checks++;
        if (wr_log.size() - w0 != ew.size()) begin
            failures++; $display("FAIL rand_write_count got=%0d exp=%0d", wr_log.size() - w0, ew.size());
        end else begin
            foreach (ew[k]) begin
                checks++;
                if (wr_log[w0+k] !== ew[k]) begin
                    failures++; $display("FAIL rand_write[%0d] got=%h/%h exp=%h/%h", k, wr_log[w0+k].addr, wr_log[w0+k].data, ew[k].addr, ew[k].data);
                end
            end
        end
        checks++; if (done_cnt - d0 != ed) begin failures++; $display("FAIL rand_done got=%0d exp=%0d", done_cnt - d0, ed); end
        checks++; if (load_err !== 1'(ee)) begin failures++; $display("FAIL rand_err got=%b exp=%0d", load_err, ee); end
    endtask

    task automatic test_back_to_back();
        bq_t s = '{8'hA5, 8'h03, 8'h00};
        bq_t d;
        wq_t ew;
        int ed;
        int ee;
        int w0 = wr_log.size();
        for (int k = 0; k < 12; k++) d.push_back(8'($urandom));
        foreach (d[k]) s.push_back(d[k]);
`ifdef LOADER_CHECKSUM_EN
        s.push_back(xor_words(d));
`endif
        model(s, ew, ed, ee);
        gap_max = 0;
        send_stream(s);
        checks++;
        if (wr_log.size() - w0 != 3) begin
            failures++; $display("FAIL b2b_count got=%0d exp=3", wr_log.size() - w0);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (wr_log[w0+k] !== ew[k]) begin
                    failures++; $display("FAIL b2b_word[%0d] got=%h/%h exp=%h/%h", k, wr_log[w0+k].addr, wr_log[w0+k].data, ew[k].addr, ew[k].data);
                end
            end
            for (int k = 1; k < 3; k++) begin
                checks++;
                if (we_cyc[w0+k] - we_cyc[w0+k-1] != 5) begin
                    failures++; $display("FAIL b2b_spacing[%0d] got=%0d exp=5", k, we_cyc[w0+k] - we_cyc[w0+k-1]);
                end
            end
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int w0 = wr_log.size();
        int d0 = done_cnt;
        gap_max = 0;
        send_stream('{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04});
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL chk_good_done got=%0d exp=1", done_cnt - d0); end
        checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL chk_good_err got=%b exp=0", load_err); end
        send_stream('{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
        checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL chk_bad_err got=%b exp=1", load_err); end
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL chk_bad_done got=%0d exp=1", done_cnt - d0); end
        checks++;
        if (wr_log.size() - w0 != 2) begin
            failures++; $display("FAIL chk_write_count got=%0d exp=2", wr_log.size() - w0);
        end else if (wr_log[w0+1] !== {12'h000, 32'h04030201}) begin
            failures++; $display("FAIL chk_bad_word got=%h/%h exp=000/04030201", wr_log[w0+1].addr, wr_log[w0+1].data);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_two_words();
        test_leading_junk();
        test_len_err();
        test_reset_abort();
        test_random();
        test_back_to_back();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        checks++; if (hold_bad != 0) begin failures++; $display("FAIL cpu_hold_window got=%0d violations exp=0", hold_bad); end
        checks++; if (ready_bad != 0) begin failures++; $display("FAIL ready_during_write got=%0d exp=0", ready_bad); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
